// File: rtl/seq_counter_ctrl.sv
// Sequencer that steps a 4-bit code through a fixed 8-entry cycle under run/pause/step/abort control.
// Optional build macro SEQ_TARGET_STOP_EN adds a target port that ends a run when q reaches it.
module seq_counter_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    input  logic             pause,
    input  logic             step,
    input  logic             abort,
    input  logic             load,
    input  logic [3:0]       load_code,
    output logic [3:0]       q,
    output logic [2:0]       idx,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] remaining
`ifdef SEQ_TARGET_STOP_EN
    ,
    input  logic [3:0]       target
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] REM_ONE = CNT_W'(1);

    state_t           state_r, state_nxt_s;
    logic [3:0]       q_r, q_nxt_s;
    logic [2:0]       idx_r, idx_nxt_s;
    logic             err_r, err_nxt_s;
    logic             busy_r, done_r;
    logic [CNT_W-1:0] rem_r, rem_nxt_s;

    logic [2:0]       adv_idx_s;
    logic [3:0]       adv_code_s;
    logic [3:0]       lookup_s;
    logic             hit_s;
    logic             adv_fin_s;
    logic [CNT_W-1:0] adv_rem_s;

    function automatic logic [3:0] code_of(input logic [2:0] i);
        logic [3:0] c;
        case (i)
            3'd0:    c = 4'b0000;
            3'd1:    c = 4'b1101;
            3'd2:    c = 4'b1011;
            3'd3:    c = 4'b1001;
            3'd4:    c = 4'b0110;
            3'd5:    c = 4'b1100;
            3'd6:    c = 4'b0011;
            3'd7:    c = 4'b1111;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

    // Returns {legal, position}; illegal codes report legal=0.
    function automatic logic [3:0] pos_of(input logic [3:0] c);
        logic [3:0] p;
        case (c)
            4'b0000: p = 4'b1_000;
            4'b1101: p = 4'b1_001;
            4'b1011: p = 4'b1_010;
            4'b1001: p = 4'b1_011;
            4'b0110: p = 4'b1_100;
            4'b1100: p = 4'b1_101;
            4'b0011: p = 4'b1_110;
            4'b1111: p = 4'b1_111;
            default: p = 4'b0_000;
        endcase
        return p;
    endfunction

    // Next-state and next-value decode; abort > load > start > pause > step.
    always_comb begin
        state_nxt_s = state_r;
        q_nxt_s     = q_r;
        idx_nxt_s   = idx_r;
        err_nxt_s   = err_r;
        rem_nxt_s   = rem_r;

        adv_idx_s  = idx_r + 3'd1;
        adv_code_s = code_of(adv_idx_s);
        lookup_s   = pos_of(load_code);
`ifdef SEQ_TARGET_STOP_EN
        hit_s      = (adv_code_s == target);
`else
        hit_s      = 1'b0;
`endif
        // remaining is nonzero throughout a counted run and zero in free-run
        adv_fin_s  = hit_s || ((rem_r != '0) && (rem_r == REM_ONE));
        if (hit_s || (rem_r == '0)) begin
            adv_rem_s = rem_r;
        end else begin
            adv_rem_s = rem_r - REM_ONE;
        end

        case (state_r)
            IDLE: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (load) begin
                    if (lookup_s[3]) begin
                        q_nxt_s   = load_code;
                        idx_nxt_s = lookup_s[2:0];
                    end else begin
                        q_nxt_s   = 4'b0000;
                        idx_nxt_s = 3'd0;
                        err_nxt_s = 1'b1;
                    end
                end else if (start) begin
                    state_nxt_s = RUN;
                    rem_nxt_s   = steps;
                    err_nxt_s   = 1'b0;
                end else if (step) begin
                    q_nxt_s   = adv_code_s;
                    idx_nxt_s = adv_idx_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (pause) begin
                    state_nxt_s = PAUSED;
                end else begin
                    q_nxt_s   = adv_code_s;
                    idx_nxt_s = adv_idx_s;
                    rem_nxt_s = adv_rem_s;
                    if (adv_fin_s) begin
                        state_nxt_s = FINISH;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
            end
            PAUSED: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (load) begin
                    if (lookup_s[3]) begin
                        q_nxt_s   = load_code;
                        idx_nxt_s = lookup_s[2:0];
                    end else begin
                        q_nxt_s   = 4'b0000;
                        idx_nxt_s = 3'd0;
                        err_nxt_s = 1'b1;
                    end
                end else if (!pause) begin
                    state_nxt_s = RUN;
                end else if (step) begin
                    q_nxt_s   = adv_code_s;
                    idx_nxt_s = adv_idx_s;
                    rem_nxt_s = adv_rem_s;
                    if (adv_fin_s) begin
                        state_nxt_s = FINISH;
                    end else begin
                        state_nxt_s = PAUSED;
                    end
                end else begin
                    state_nxt_s = PAUSED;
                end
            end
            FINISH: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and output registers; busy/done are registered from the next state.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_r <= IDLE;
            q_r     <= 4'b0000;
            idx_r   <= 3'd0;
            err_r   <= 1'b0;
            rem_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            q_r     <= q_nxt_s;
            idx_r   <= idx_nxt_s;
            err_r   <= err_nxt_s;
            rem_r   <= rem_nxt_s;
            busy_r  <= (state_nxt_s == RUN) || (state_nxt_s == PAUSED);
            done_r  <= (state_nxt_s == FINISH);
        end
    end

    assign q         = q_r;
    assign idx       = idx_r;
    assign err       = err_r;
    assign remaining = rem_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Directed bench for seq_counter_ctrl; target-stop case runs only when SEQ_TARGET_STOP_EN is defined.
module tb_seq_counter_ctrl;

    logic       clk = 1'b0;
    logic       clear;
    logic       start;
    logic [7:0] steps;
    logic       pause;
    logic       step;
    logic       abort;
    logic       load;
    logic [3:0] load_code;
    logic [3:0] q;
    logic [2:0] idx;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] remaining;
`ifdef SEQ_TARGET_STOP_EN
    logic [3:0] target;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] seq_exp [8] = '{4'hD, 4'hB, 4'h9, 4'h6, 4'hC, 4'h3, 4'hF, 4'h0};

    seq_counter_ctrl #(.CNT_W(8)) dut (
        .clk       (clk),
        .clear     (clear),
        .start     (start),
        .steps     (steps),
        .pause     (pause),
        .step      (step),
        .abort     (abort),
        .load      (load),
        .load_code (load_code),
        .q         (q),
        .idx       (idx),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .remaining (remaining)
`ifdef SEQ_TARGET_STOP_EN
        ,
        .target    (target)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clear = 1'b0; start = 1'b0; steps = 8'd0; pause = 1'b0; step = 1'b0;
        abort = 1'b0; load = 1'b0; load_code = 4'h0;
`ifdef SEQ_TARGET_STOP_EN
        target = 4'h3;
`endif
        #3;
        check("rst_q", q, 4'h0);
        check("rst_idx", idx, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rem", remaining, 8'd0);
        #20 clear = 1'b1;
        tick();
        check("post_rst_q", q, 4'h0);

        // Full counted run of 8 from 0000
        start = 1'b1; steps = 8'd8;
        tick();
        start = 1'b0;
        check("run8_busy0", busy, 1'b1);
        check("run8_rem0", remaining, 8'd8);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("run8_q", q, seq_exp[i]);
            check("run8_idx", idx, (i + 1) % 8);
            check("run8_busy", busy, (i < 7) ? 1'b1 : 1'b0);
            check("run8_done", done, (i == 7) ? 1'b1 : 1'b0);
        end
        check("run8_rem_end", remaining, 8'd0);
        tick();
        check("run8_done_off", done, 1'b0);
        check("run8_busy_off", busy, 1'b0);

        // Legal then illegal load in IDLE, start clears err
        load = 1'b1; load_code = 4'b0110;
        tick();
        check("ld_ok_q", q, 4'h6);
        check("ld_ok_idx", idx, 3'd4);
        check("ld_ok_err", err, 1'b0);
        load_code = 4'b0101;
        tick();
        check("ld_bad_q", q, 4'h0);
        check("ld_bad_idx", idx, 3'd0);
        check("ld_bad_err", err, 1'b1);
        load = 1'b0; start = 1'b1; steps = 8'd2;
        tick();
        start = 1'b0;
        check("st_err_clr", err, 1'b0);
        check("st2_busy", busy, 1'b1);
        tick();
        tick();
        check("st2_q", q, 4'hB);
        check("st2_done", done, 1'b1);
        tick();

        // Pause / step / resume with steps=5
        load = 1'b1; load_code = 4'h0;
        tick();
        load = 1'b0; start = 1'b1; steps = 8'd5;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pz_q_pre", q, 4'hB);
        pause = 1'b1;
        tick();
        check("pz_hold_q", q, 4'hB);
        check("pz_hold_rem", remaining, 8'd3);
        check("pz_busy", busy, 1'b1);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("pz_step_q", q, 4'h9);
        check("pz_step_rem", remaining, 8'd2);
        tick();
        check("pz_hold2_q", q, 4'h9);
        pause = 1'b0;
        tick();
        check("pz_resume_q", q, 4'h9);
        check("pz_resume_done", done, 1'b0);
        tick();
        check("pz_adv1_q", q, 4'h6);
        check("pz_adv1_done", done, 1'b0);
        tick();
        check("pz_end_q", q, 4'hC);
        check("pz_end_done", done, 1'b1);
        check("pz_end_rem", remaining, 8'd0);
        tick();

        // Abort mid-run at 1001
        load = 1'b1; load_code = 4'h0;
        tick();
        load = 1'b0; start = 1'b1; steps = 8'd10;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("ab_q_pre", q, 4'h9);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", busy, 1'b0);
        check("ab_q", q, 4'h9);
        check("ab_rem", remaining, 8'd7);
        check("ab_done", done, 1'b0);
        tick();
        check("ab_done2", done, 1'b0);
        check("ab_q2", q, 4'h9);

        // Single step in IDLE leaves remaining alone
        step = 1'b1;
        tick();
        step = 1'b0;
        check("idle_step_q", q, 4'h6);
        check("idle_step_idx", idx, 3'd4);
        check("idle_step_rem", remaining, 8'd7);
        check("idle_step_busy", busy, 1'b0);

        // Load ignored in RUN
        load = 1'b1; load_code = 4'h0;
        tick();
        load = 1'b0; start = 1'b1; steps = 8'd0;
        tick();
        start = 1'b0;
        check("fr_rem", remaining, 8'd0);
        check("fr_busy", busy, 1'b1);
        load = 1'b1; load_code = 4'hF;
        tick();
        load = 1'b0;
        check("run_ld_ign_q", q, 4'hD);
        tick();
        tick();
        tick();
        check("fr_q", q, 4'h6);
        check("fr_rem2", remaining, 8'd0);

        // Asynchronous clear mid-run
        #2 clear = 1'b0;
        #1;
        check("clr_q", q, 4'h0);
        check("clr_busy", busy, 1'b0);
        check("clr_idx", idx, 3'd0);
        #2 clear = 1'b1;
        tick();
        check("clr_noresume_busy", busy, 1'b0);
        check("clr_noresume_q", q, 4'h0);
        start = 1'b1; abort = 1'b1; steps = 8'd4;
        tick();
        start = 1'b0; abort = 1'b0;
        check("st_ab_busy", busy, 1'b0);
        check("st_ab_q", q, 4'h0);
        check("st_ab_rem", remaining, 8'd0);

`ifdef SEQ_TARGET_STOP_EN
        // Free-run stopped by target 0011
        target = 4'h3;
        start = 1'b1; steps = 8'd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("tg_q", q, seq_exp[i]);
            check("tg_done", done, (i == 5) ? 1'b1 : 1'b0);
        end
        check("tg_rem", remaining, 8'd0);
        tick();
        check("tg_idle_busy", busy, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
